// File: rtl/inst_mem_loader_pkg.sv
// Shared widths, state encoding and word-packing helper for the instruction-memory loader.
package inst_mem_loader_pkg;

   localparam int INST_BUS_W      = 32;
   localparam int INST_ADDR_W     = 32;
   localparam int LD_BYTE_W       = 8;
   localparam logic [INST_BUS_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_LOAD,
      ST_RUN,
      ST_ERR
   } ld_state_e;

   // Left-justify the bytes collected so far plus the incoming one; missing low bytes are zero.
   function automatic logic [INST_BUS_W-1:0] pad_word(input logic [23:0]          shift,
                                                      input logic [LD_BYTE_W-1:0] b,
                                                      input logic [1:0]           cnt);
      logic [INST_BUS_W-1:0] w;
      case (cnt)
         2'd0:    w = {b, 24'h0};
         2'd1:    w = {shift[7:0], b, 16'h0};
         2'd2:    w = {shift[15:0], b, 8'h0};
         default: w = {shift, b};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/inst_mem_loader_byte_word_assembler.sv
// Packs accepted load bytes MSB-first into 32-bit words; strobes word_vld on the
// fourth byte or on a last byte that closes a partial word.
module byte_word_assembler
   import inst_mem_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  acc,
   input  logic [LD_BYTE_W-1:0]  ld_byte,
   input  logic                  ld_last,
   output logic                  word_vld,
   output logic [INST_BUS_W-1:0] word
);

   logic [23:0] shift_q;
   logic [1:0]  cnt_q;

   assign word_vld = acc & (ld_last | (cnt_q == 2'd3));
   assign word     = pad_word(shift_q, ld_byte, cnt_q);

   // Stale shift bytes after a word completes are harmless: cnt_q masks them out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clr) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (acc) begin
         shift_q <= {shift_q[15:0], ld_byte};
         cnt_q   <= word_vld ? 2'd0 : cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with byte-serial program loader; holds the core in reset while loading.
// Optional load checksum on chk_o when INST_MEM_CHECKSUM_EN is defined.
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int                    DEPTH_LOG2 = 10,
   parameter logic [INST_BUS_W-1:0] NOP_WORD   = NOP_INST
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic [INST_ADDR_W-1:0] addr,
   output logic [INST_BUS_W-1:0]  inst,
   input  logic                   ld_start,
   input  logic                   ld_valid,
   input  logic [LD_BYTE_W-1:0]   ld_byte,
   input  logic                   ld_last,
   output logic                   ld_ready,
   output logic                   ld_done,
   output logic [DEPTH_LOG2:0]    word_count,
   output logic                   cpu_rst_o,
   output logic                   err_o,
   output logic [INST_BUS_W-1:0]  chk_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   ld_state_e              state_q, state_d;
   logic [DEPTH_LOG2:0]    wc_q;
   logic                   full, byte_ok, acc;
   logic                   word_vld;
   logic [INST_BUS_W-1:0]  word;
   logic [INST_BUS_W-1:0]  mem [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0]  idx;
   logic                   in_range;
   logic                   unused_addr_lo;

   // word_count never exceeds DEPTH, so its MSB alone flags a full array.
   assign full     = wc_q[DEPTH_LOG2];
   assign ld_ready = (state_q == ST_LOAD) & ~ld_start;
   assign byte_ok  = ld_valid & ld_ready;
   assign acc      = byte_ok & ~full;

   assign ld_done    = (state_q == ST_RUN);
   assign cpu_rst_o  = (state_q != ST_RUN);
   assign err_o      = (state_q == ST_ERR);
   assign word_count = wc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_HOLD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ld_start) begin
         state_d = ST_LOAD;
      end else begin
         case (state_q)
            ST_LOAD: if (byte_ok) begin
               if (full)         state_d = ST_ERR;
               else if (ld_last) state_d = ST_RUN;
            end
            default: state_d = state_q;
         endcase
      end
   end

   byte_word_assembler u_asm (
      .clk      (clk),
      .rst      (rst),
      .clr      (ld_start),
      .acc      (acc),
      .ld_byte  (ld_byte),
      .ld_last  (ld_last),
      .word_vld (word_vld),
      .word     (word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           wc_q <= '0;
      else if (ld_start) wc_q <= '0;
      else if (word_vld) wc_q <= wc_q + 1'b1;
   end

   // Array is deliberately not reset; word_count gates what is readable.
   always_ff @(posedge clk) begin
      if (word_vld) mem[wc_q[DEPTH_LOG2-1:0]] <= word;
   end

   assign idx            = addr[DEPTH_LOG2+1:2];
   assign in_range       = (addr[INST_ADDR_W-1:DEPTH_LOG2+2] == '0);
   assign unused_addr_lo = ^addr[1:0];

   always_comb begin
      inst = NOP_WORD;
      if (ce && (state_q == ST_RUN) && in_range && ({1'b0, idx} < wc_q))
         inst = mem[idx];
   end

`ifdef INST_MEM_CHECKSUM_EN
   logic [INST_BUS_W-1:0] chk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           chk_q <= '0;
      else if (ld_start) chk_q <= '0;
      else if (word_vld) chk_q <= chk_q + word;
   end

   assign chk_o = chk_q;
`else
   assign chk_o = '0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a 1024-word and a 4-word instance share all inputs
// and are checked every cycle against a queue-level model plus literal expectations.
module tb_inst_mem_loader;

   localparam int M_HOLD = 0, M_LOAD = 1, M_RUN = 2, M_ERR = 3;

   logic        clk = 1'b0;
   logic        rst, ce, ld_start, ld_valid, ld_last;
   logic [31:0] addr;
   logic [7:0]  ld_byte;

   logic [31:0] inst_v [2];
   logic [31:0] chk_v  [2];
   logic        ready_v[2], done_v[2], crst_v[2], err_v[2];
   logic [10:0] wc0;
   logic [2:0]  wc1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   inst_mem_loader #(.DEPTH_LOG2(10)) u_big (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_v[0]),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
      .ld_ready(ready_v[0]), .ld_done(done_v[0]), .word_count(wc0),
      .cpu_rst_o(crst_v[0]), .err_o(err_v[0]), .chk_o(chk_v[0])
   );

   inst_mem_loader #(.DEPTH_LOG2(2)) u_small (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_v[1]),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
      .ld_ready(ready_v[1]), .ld_done(done_v[1]), .word_count(wc1),
      .cpu_rst_o(crst_v[1]), .err_o(err_v[1]), .chk_o(chk_v[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_mode[2], m_nw[2], m_nb[2], m_cap[2];
   logic [7:0]  m_pb [2][4];
   logic [31:0] m_mem[2][1024];
   logic [31:0] m_chk[2];

   function automatic void m_reset(input int k);
      m_mode[k] = M_HOLD; m_nw[k] = 0; m_nb[k] = 0; m_chk[k] = 0;
   endfunction

   function automatic void m_step(input int k);
      logic [31:0] w;
      if (ld_start) begin
         m_mode[k] = M_LOAD; m_nw[k] = 0; m_nb[k] = 0; m_chk[k] = 0;
      end else if (m_mode[k] == M_LOAD && ld_valid) begin
         if (m_nw[k] == m_cap[k]) begin
            m_mode[k] = M_ERR;
         end else begin
            m_pb[k][m_nb[k]] = ld_byte;
            m_nb[k]++;
            if (m_nb[k] == 4 || ld_last) begin
               w = 32'h0;
               for (int i = 0; i < m_nb[k]; i++) w[31-8*i -: 8] = m_pb[k][i];
               m_mem[k][m_nw[k]] = w;
               m_nw[k]++;
               m_chk[k] += w;
               m_nb[k] = 0;
            end
            if (ld_last) m_mode[k] = M_RUN;
         end
      end
   endfunction

   function automatic logic [31:0] m_inst(input int k);
      if (ce === 1'b1 && m_mode[k] == M_RUN && int'(addr >> 2) < m_nw[k])
         return m_mem[k][addr >> 2];
      return 32'h0;
   endfunction

   initial begin
      m_cap[0] = 1024; m_cap[1] = 4;
      m_reset(0); m_reset(1);
      forever begin
         @(posedge clk or posedge rst);
         for (int k = 0; k < 2; k++) begin
            if (rst) m_reset(k);
            else     m_step(k);
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("inst[%0d]", k),  inst_v[k], m_inst(k));
            check($sformatf("ready[%0d]", k), 32'(ready_v[k]), 32'(m_mode[k] == M_LOAD && !ld_start));
            check($sformatf("done[%0d]", k),  32'(done_v[k]), 32'(m_mode[k] == M_RUN));
            check($sformatf("cpurst[%0d]", k), 32'(crst_v[k]), 32'(m_mode[k] != M_RUN));
            check($sformatf("err[%0d]", k),   32'(err_v[k]), 32'(m_mode[k] == M_ERR));
            check($sformatf("wc[%0d]", k),    (k == 0) ? 32'(wc0) : 32'(wc1), 32'(m_nw[k]));
`ifdef INST_MEM_CHECKSUM_EN
            check($sformatf("chk[%0d]", k),   chk_v[k], m_chk[k]);
`else
            check($sformatf("chk[%0d]", k),   chk_v[k], 32'h0);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_load();
      ld_start = 1'b1;
      @(posedge clk); #1;
      ld_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      ld_valid = 1'b1; ld_byte = b; ld_last = last;
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(name, inst_v[0], exp);
   endtask

   logic [7:0] prog1 [8];
   logic [7:0] prog2 [5];

   initial begin
      prog1 = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
      prog2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      rst = 1'b1; ce = 1'b1; addr = 32'h0;
      ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h0;
      @(posedge clk); #1;
      check("rst_cpurst", 32'(crst_v[0]), 32'h1);
      check("rst_ready",  32'(ready_v[0]), 32'h0);
      check("rst_done",   32'(done_v[0]), 32'h0);
      check("rst_inst",   inst_v[0], 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Two full words
      start_load();
      for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
      check("p1_cpurst", 32'(crst_v[0]), 32'h0);
      check("p1_wc",     32'(wc0), 32'd2);
      fetch("p1_a0", 32'h0, 32'h3401_1100);
      fetch("p1_a4", 32'h4, 32'h3402_0020);
      fetch("p1_a8", 32'h8, 32'h0);
      fetch("p1_a6", 32'h6, 32'h3402_0020);
`ifdef INST_MEM_CHECKSUM_EN
      check("p1_chk", chk_v[0], 32'h6803_1120);
`endif
      ce = 1'b0;
      fetch("p1_ce0", 32'h0, 32'h0);
      ce = 1'b1;
      fetch("p1_oor", 32'h0000_1000, 32'h0);
      check("p1_oor_small", inst_v[1], 32'h0);
      addr = 32'h0;
      @(posedge clk); #1;

      // Partial last word zero-padded
      start_load();
      for (int i = 0; i < 5; i++) send_byte(prog2[i], i == 4);
      check("p2_wc", 32'(wc0), 32'd2);
      fetch("p2_a4", 32'h4, 32'hEE00_0000);
      fetch("p2_a0", 32'h0, 32'hAABB_CCDD);
      @(posedge clk); #1;

      // Overflow on the 4-word instance
      start_load();
      for (int i = 0; i < 17; i++) send_byte(8'(i + 1), 1'b0);
      check("ov_err",    32'(err_v[1]), 32'h1);
      check("ov_wc",     32'(wc1), 32'd4);
      check("ov_cpurst", 32'(crst_v[1]), 32'h1);
      check("ov_big_err", 32'(err_v[0]), 32'h0);
      start_load();
      check("ov_clr_err", 32'(err_v[1]), 32'h0);
      check("ov_clr_wc",  32'(wc1), 32'd0);

      // ld_start beats a simultaneous byte
      send_byte(8'h99, 1'b0);
      send_byte(8'h88, 1'b0);
      ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h55;
      #1;
      check("sv_ready", 32'(ready_v[0]), 32'h0);
      @(posedge clk); #1;
      ld_start = 1'b0; ld_valid = 1'b0;
      check("sv_wc", 32'(wc0), 32'd0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      fetch("sv_a0", 32'h0, 32'h1122_3344);
      addr = 32'h0;

      // Asynchronous reset mid-load
      start_load();
      for (int i = 0; i < 5; i++) send_byte(8'h70 + 8'(i), 1'b0);
      check("ar_wc_pre", 32'(wc0), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_ready",  32'(ready_v[0]), 32'h0);
      check("ar_wc",     32'(wc0), 32'd0);
      check("ar_cpurst", 32'(crst_v[0]), 32'h1);
      check("ar_done",   32'(done_v[0]), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("ar_hold_ready", 32'(ready_v[0]), 32'h0);
      start_load();
      send_byte(8'hC0, 1'b0);
      send_byte(8'hDE, 1'b1);
      fetch("ar_reload", 32'h0, 32'hC0DE_0000);

      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
